// File: rtl/calc_display_driver.sv
// Calculator result display: converts an 8-bit value to BCD by double-dabble
// and time-multiplexes three 7-segment digits with leading-zero blanking.
module calc_display_driver #(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] num_in,
  output logic [6:0] seg_out,
  output logic [2:0] dig_sel,
  output logic       busy
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q;
  logic [7:0]    last_q;
  logic [7:0]    bin_q;
  logic [11:0]   bcd_q;
  logic [11:0]   disp_q;
  logic [2:0]    iter_q;
  logic          busy_q;
  logic [SW-1:0] scan_q;
  logic [1:0]    idx_q;
  logic [3:0]    nib_d;
  logic          blank_d;

  function automatic logic [19:0] dabble(input logic [11:0] bcd, input logic [7:0] bin);
    logic [11:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return {adj[10:0], bin, 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // iter_q counts remaining shifts; the shift taken at zero is the eighth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (num_in != last_q) begin
            bin_q   <= num_in;
            last_q  <= num_in;
            bcd_q   <= '0;
            iter_q  <= 3'd7;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= dabble(bcd_q, bin_q);
          iter_q <= iter_q - 3'd1;
          if (iter_q == 3'd0) state_q <= DONE;
        end
        DONE: begin
          disp_q  <= bcd_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (ena) begin
      if (scan_q == SCAN_MAX) begin
        scan_q <= '0;
        idx_q  <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
    end
  end

  always_comb begin
    nib_d   = disp_q[3:0];
    blank_d = 1'b0;
    dig_sel = 3'b001;
    case (idx_q)
      2'd1: begin
        nib_d   = disp_q[7:4];
        blank_d = (disp_q[11:4] == 8'h00);
        dig_sel = 3'b010;
      end
      2'd2: begin
        nib_d   = disp_q[11:8];
        blank_d = (disp_q[11:8] == 4'h0);
        dig_sel = 3'b100;
      end
      default: ;
    endcase
    seg_out = blank_d ? 7'h00 : seg_decode(nib_d);
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// Randomised and directed bench for calc_display_driver against a decimal
// reference model (pending value + busy countdown + enabled-cycle scan count).
module tb_calc_display_driver;
  localparam int SCAN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] num_in;
  logic [6:0] seg_out;
  logic [2:0] dig_sel;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int m_busy = 0, m_last = 0, m_pend = 0, m_disp = 0, m_en = 0;

  calc_display_driver #(.SCAN_DIV(SCAN)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .num_in(num_in),
    .seg_out(seg_out), .dig_sel(dig_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segc(input int n);
    case (n)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F; default: return 7'h00;
    endcase
  endfunction

  // expected {busy, dig_sel, seg_out}
  function automatic logic [10:0] exp_out();
    int h, t, o, d, n;
    logic [6:0] s;
    h = m_disp / 100; t = (m_disp / 10) % 10; o = m_disp % 10;
    d = (m_en / SCAN) % 3;
    n = (d == 0) ? o : (d == 1) ? t : h;
    s = segc(n);
    if (d == 2 && h == 0) s = 7'h00;
    if (d == 1 && h == 0 && t == 0) s = 7'h00;
    return {(m_busy > 0), 3'(1 << d), s};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_last = 0; m_disp = 0; m_en = 0;
    end else if (ena) begin
      m_en++;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_disp = m_pend;
      end else if (int'(num_in) != m_last) begin
        m_last = int'(num_in); m_pend = int'(num_in); m_busy = 9;
      end
    end
    #1;
  endtask

  task automatic convert(input logic [7:0] v, output int bcyc);
    num_in = v;
    bcyc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (busy) bcyc++;
      else if (bcyc > 0) break;
    end
  endtask

  task automatic collect(output logic [6:0] s0, output logic [6:0] s1, output logic [6:0] s2);
    s0 = 'x; s1 = 'x; s2 = 'x;
    for (int i = 0; i < 3 * SCAN; i++) begin
      tick();
      case (dig_sel)
        3'b001: s0 = seg_out;
        3'b010: s1 = seg_out;
        3'b100: s2 = seg_out;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; num_in = 8'd0;
    tick(); tick();
    if ({busy, dig_sel, seg_out} !== {1'b0, 3'b001, 7'h3F}) begin
      n_err++; $display("FAIL reset_vals: got %h exp %h", {busy, dig_sel, seg_out}, {1'b0, 3'b001, 7'h3F});
    end
    n_vec++;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ({busy, dig_sel, seg_out} !== exp_out() || busy !== 1'b0) begin
        n_err++; $display("FAIL reset_idle cyc %0d: got %h exp %h", i, {busy, dig_sel, seg_out}, exp_out());
      end
      n_vec++;
    end
  endtask

  task automatic test_255();
    int b;
    logic [6:0] s0, s1, s2;
    convert(8'd255, b);
    if (b !== 9) begin n_err++; $display("FAIL busy_255: got %0d cycles exp 9", b); end
    n_vec++;
    if ({busy, dig_sel, seg_out} !== exp_out()) begin
      n_err++; $display("FAIL model_255: got %h exp %h", {busy, dig_sel, seg_out}, exp_out());
    end
    n_vec++;
    collect(s0, s1, s2);
    if ({s2, s1, s0} !== {7'h5B, 7'h6D, 7'h6D}) begin
      n_err++; $display("FAIL digits_255: got %h exp %h", {s2, s1, s0}, {7'h5B, 7'h6D, 7'h6D});
    end
    n_vec++;
    for (int i = 0; i < 13; i++) begin
      tick();
      if ({busy, dig_sel, seg_out} !== exp_out()) begin
        n_err++; $display("FAIL scan_255 cyc %0d: got %h exp %h", i, {busy, dig_sel, seg_out}, exp_out());
      end
      n_vec++;
    end
  endtask

  task automatic test_blanking();
    int b;
    logic [6:0] s0, s1, s2;
    convert(8'd7, b);
    collect(s0, s1, s2);
    if ({s2, s1, s0} !== {7'h00, 7'h00, 7'h07}) begin
      n_err++; $display("FAIL blank_7: got %h exp %h", {s2, s1, s0}, {7'h00, 7'h00, 7'h07});
    end
    n_vec++;
    convert(8'd105, b);
    if (b !== 9) begin n_err++; $display("FAIL busy_105: got %0d cycles exp 9", b); end
    n_vec++;
    collect(s0, s1, s2);
    if ({s2, s1, s0} !== {7'h06, 7'h3F, 7'h6D}) begin
      n_err++; $display("FAIL blank_105: got %h exp %h", {s2, s1, s0}, {7'h06, 7'h3F, 7'h6D});
    end
    n_vec++;
  endtask

  task automatic test_ena_freeze();
    int b;
    logic [10:0] snap;
    logic [6:0] s0, s1, s2;
    num_in = 8'd200;
    b = 0;
    repeat (3) begin tick(); if (busy) b++; end
    ena = 1'b0;
    snap = {busy, dig_sel, seg_out};
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({busy, dig_sel, seg_out} !== snap || {busy, dig_sel, seg_out} !== exp_out()) begin
        n_err++; $display("FAIL freeze cyc %0d: got %h exp %h", i, {busy, dig_sel, seg_out}, snap);
      end
      n_vec++;
      if (busy) b++;
    end
    ena = 1'b1;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      if (busy) b++;
    end
    if (b !== 14) begin n_err++; $display("FAIL freeze_busy: got %0d cycles exp 14", b); end
    n_vec++;
    collect(s0, s1, s2);
    if ({s2, s1, s0} !== {7'h5B, 7'h3F, 7'h3F}) begin
      n_err++; $display("FAIL freeze_200: got %h exp %h", {s2, s1, s0}, {7'h5B, 7'h3F, 7'h3F});
    end
    n_vec++;
  endtask

  task automatic test_back_to_back();
    int nb, gap, phase;
    logic [6:0] s0, s1, s2;
    num_in = 8'd10;
    nb = 0; gap = 0; phase = 0;
    repeat (2) begin tick(); if (busy) nb++; end
    num_in = 8'd200;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ({busy, dig_sel, seg_out} !== exp_out()) begin
        n_err++; $display("FAIL b2b cyc %0d: got %h exp %h", i, {busy, dig_sel, seg_out}, exp_out());
      end
      n_vec++;
      if (busy) begin nb++; if (phase == 1) phase = 2; end
      else if (phase == 0) begin phase = 1; gap++; end
      else if (phase == 1) gap++;
      else break;
    end
    if (gap !== 1 || nb !== 18) begin
      n_err++; $display("FAIL b2b_gap: got gap %0d busy %0d exp gap 1 busy 18", gap, nb);
    end
    n_vec++;
    collect(s0, s1, s2);
    if ({s2, s1, s0} !== {7'h5B, 7'h3F, 7'h3F}) begin
      n_err++; $display("FAIL b2b_200: got %h exp %h", {s2, s1, s0}, {7'h5B, 7'h3F, 7'h3F});
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    int b;
    logic [6:0] s0, s1, s2;
    num_in = 8'd42;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    if ({busy, dig_sel, seg_out} !== {1'b0, 3'b001, 7'h3F}) begin
      n_err++; $display("FAIL mid_reset: got %h exp %h", {busy, dig_sel, seg_out}, {1'b0, 3'b001, 7'h3F});
    end
    n_vec++;
    rst_n = 1'b1;
    convert(8'd42, b);
    if (b !== 9) begin n_err++; $display("FAIL busy_42: got %0d cycles exp 9", b); end
    n_vec++;
    collect(s0, s1, s2);
    if ({s2, s1, s0} !== {7'h00, 7'h66, 7'h5B}) begin
      n_err++; $display("FAIL digits_42: got %h exp %h", {s2, s1, s0}, {7'h00, 7'h66, 7'h5B});
    end
    n_vec++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) num_in = 8'($urandom);
      ena   = ($urandom_range(5) != 0);
      rst_n = ($urandom_range(99) != 0);
      tick();
      if ({busy, dig_sel, seg_out} !== exp_out()) begin
        n_err++; $display("FAIL random cyc %0d: got %h exp %h", i, {busy, dig_sel, seg_out}, exp_out());
      end
      n_vec++;
    end
    rst_n = 1'b1; ena = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; num_in = 8'd0;
    test_reset();
    test_255();
    test_blanking();
    test_ena_freeze();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
